// File: rtl/alu.sv
// 16-bit signed ALU for the execute stage with a registered status nibble.
// Define ALU_STICKY_EN to add the err_sticky error latch.
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             div0,
`ifdef ALU_STICKY_EN
  output logic             err_sticky,
`endif
  output logic [3:0]       flags_q
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  logic [WIDTH-1:0]          add_r;
  logic [WIDTH-1:0]          sub_r;
  logic signed [2*WIDTH-1:0] lhs_w;
  logic signed [2*WIDTH-1:0] rhs_w;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH:0]     lhs_x;
  logic signed [WIDTH:0]     dvs_x;
  logic signed [WIDTH:0]     quo_x;
  logic signed [WIDTH:0]     rem_x;
  logic                      rhs_zero;
  logic                      unused_rem_msb;
  logic [3:0]                flags_d;

  // One guard bit on the divider keeps -min/-1 representable,
  // and a dummy divisor of 1 keeps the divider X-free on rhs==0.
  assign rhs_zero = (rhs == '0);
  assign add_r    = lhs + rhs;
  assign sub_r    = lhs - rhs;
  assign lhs_w    = {{WIDTH{lhs[WIDTH-1]}}, lhs};
  assign rhs_w    = {{WIDTH{rhs[WIDTH-1]}}, rhs};
  assign prod     = lhs_w * rhs_w;
  assign lhs_x    = {lhs[WIDTH-1], lhs};
  assign dvs_x    = rhs_zero ? (WIDTH+1)'(1)
                             : {rhs[WIDTH-1], rhs};
  assign quo_x    = lhs_x / dvs_x;
  assign rem_x    = lhs_x % dvs_x;
  assign unused_rem_msb = rem_x[WIDTH];

  // Operation select: result and the op-specific ovf/div0 flags.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    div0   = 1'b0;
    unique case (op)
      OP_ADD: begin
        result = add_r;
        ovf    = (lhs[WIDTH-1] == rhs[WIDTH-1]) &&
                 (add_r[WIDTH-1] != lhs[WIDTH-1]);
      end
      OP_SUB: begin
        result = sub_r;
        ovf    = (lhs[WIDTH-1] != rhs[WIDTH-1]) &&
                 (sub_r[WIDTH-1] != lhs[WIDTH-1]);
      end
      OP_MUL: begin
        result = prod[WIDTH-1:0];
        ovf    = (prod[2*WIDTH-1:WIDTH-1] != '0) &&
                 (prod[2*WIDTH-1:WIDTH-1] != '1);
      end
      OP_DIV: begin
        div0 = rhs_zero;
        if (rhs_zero) begin
          result = '1;
        end else begin
          result = quo_x[WIDTH-1:0];
          ovf    = quo_x[WIDTH] != quo_x[WIDTH-1];
        end
      end
      OP_MOD: begin
        div0   = rhs_zero;
        result = rhs_zero ? lhs : rem_x[WIDTH-1:0];
      end
      OP_AND: result = lhs & rhs;
      OP_OR:  result = lhs | rhs;
      OP_XOR: result = lhs ^ rhs;
      default: result = '0;
    endcase
  end

  assign zero    = (result == '0);
  assign neg     = result[WIDTH-1];
  assign flags_d = {div0, ovf, neg, zero};

  // Status register: snapshot of this cycle's flags.
  always_ff @(posedge clk) begin
    if (rst) flags_q <= 4'b0;
    else     flags_q <= flags_d;
  end

`ifdef ALU_STICKY_EN
  logic err_sticky_d;
  logic err_sticky_q;

  // Error latch sets on any div0/ovf and holds until reset.
  always_comb begin
    err_sticky_d = err_sticky_q | div0 | ovf;
  end

  // Sticky error flop; reset wins over a same-cycle error.
  always_ff @(posedge clk) begin
    if (rst) err_sticky_q <= 1'b0;
    else     err_sticky_q <= err_sticky_d;
  end

  assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver pushes expectations,
// monitor pops and compares one cycle-aligned vector at a time.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  op  = '0;
  logic [15:0] lhs = '0;
  logic [15:0] rhs = '0;
  logic [15:0] result;
  logic        zero, neg, ovf, div0;
  logic [3:0]  flags_q;
`ifdef ALU_STICKY_EN
  logic        err_sticky;
`endif

  logic vld  = 1'b0;
  logic done = 1'b0;
  logic st_m = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    string       nm;
    logic [15:0] res;
    logic [3:0]  fl;
    logic [3:0]  fq;
    logic        st;
  } exp_t;

  exp_t sb[$];

  alu dut (
    .clk(clk), .rst(rst), .op(op), .lhs(lhs), .rhs(rhs),
    .result(result), .zero(zero), .neg(neg),
    .ovf(ovf), .div0(div0),
`ifdef ALU_STICKY_EN
    .err_sticky(err_sticky),
`endif
    .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [15:0] act,
                     logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic vec(string nm, logic [2:0] o,
                     logic [15:0] l, logic [15:0] r,
                     logic [15:0] res, logic ov,
                     logic d0, logic rs);
    exp_t e;
    @(negedge clk);
    op  = o;
    lhs = l;
    rhs = r;
    rst = rs;
    vld = 1'b1;
    e.nm  = nm;
    e.res = res;
    e.fl  = {d0, ov, res[15], res == 16'h0};
    e.fq  = rs ? 4'b0 : e.fl;
    st_m  = rs ? 1'b0 : (st_m | d0 | ov);
    e.st  = st_m;
    sb.push_back(e);
  endtask

  // Monitor: after each edge, check the vector held across it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (vld) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 16'd1, 16'd0);
        end else begin
          e = sb.pop_front();
          chk({e.nm, ".result"}, result, e.res);
          chk({e.nm, ".flags"},
              {12'h0, div0, ovf, neg, zero}, {12'h0, e.fl});
          chk({e.nm, ".flags_q"}, {12'h0, flags_q},
              {12'h0, e.fq});
`ifdef ALU_STICKY_EN
          chk({e.nm, ".sticky"}, {15'h0, err_sticky},
              {15'h0, e.st});
`endif
        end
      end
    end
  end

  // Driver: directed vectors with hand-computed results.
  initial begin
    vec("rst_add", 3'd0, 16'd3, 16'd4, 16'd7, 0, 0, 1);
    vec("rst_div0", 3'd3, 16'd5, 16'd0, 16'hFFFF, 0, 1, 1);
    vec("add", 3'd0, 16'd100, 16'd23, 16'd123, 0, 0, 0);
    vec("add_ovf", 3'd0, 16'd32767, 16'd1, 16'h8000, 1, 0, 0);
    vec("sub_zero", 3'd1, 16'd5, 16'd5, 16'h0000, 0, 0, 0);
    vec("sub_ovf", 3'd1, 16'h8000, 16'd1, 16'h7FFF, 1, 0, 0);
    vec("mul", 3'd2, -16'sd3, 16'd4, 16'hFFF4, 0, 0, 0);
    vec("mul_ovf", 3'd2, 16'd300, 16'd200, 16'hEA60, 1, 0, 0);
    vec("div_neg", 3'd3, -16'sd7, 16'd2, 16'hFFFD, 0, 0, 0);
    vec("div_min", 3'd3, 16'h8000, 16'hFFFF, 16'h8000, 1, 0, 0);
    vec("div_by0", 3'd3, 16'd5, 16'd0, 16'hFFFF, 0, 1, 0);
    vec("mod_by0", 3'd4, 16'd5, 16'd0, 16'd5, 0, 1, 0);
    vec("mod_nl", 3'd4, -16'sd7, 16'd2, 16'hFFFF, 0, 0, 0);
    vec("mod_nr", 3'd4, 16'd7, -16'sd2, 16'd1, 0, 0, 0);
    vec("mod_min", 3'd4, 16'h8000, 16'hFFFF, 16'h0, 0, 0, 0);
    vec("and", 3'd5, 16'h00FF, 16'h0F0F, 16'h000F, 0, 0, 0);
    vec("or", 3'd6, 16'h00FF, 16'h0F0F, 16'h0FFF, 0, 0, 0);
    vec("xor", 3'd7, 16'h00FF, 16'h0F0F, 16'h0FF0, 0, 0, 0);
    vec("mod_29_4", 3'd4, 16'd29, 16'd4, 16'd1, 0, 0, 0);
    vec("mod_28_3", 3'd4, 16'd28, 16'd3, 16'd1, 0, 0, 0);
    for (int l = 2; l <= 29; l++) begin
      for (int r = 2; r <= 29; r++) begin
        vec("mod_sweep", 3'd4, 16'(l), 16'(r),
            16'(l % r), 0, 0, 0);
      end
    end
    vec("st_rst", 3'd0, 16'd1, 16'd1, 16'd2, 0, 0, 1);
    vec("st_set", 3'd3, 16'd9, 16'd0, 16'hFFFF, 0, 1, 0);
    vec("st_hold1", 3'd5, 16'h1, 16'h3, 16'h1, 0, 0, 0);
    vec("st_hold2", 3'd6, 16'h1, 16'h2, 16'h3, 0, 0, 0);
    vec("st_clr", 3'd4, 16'd9, 16'd0, 16'd9, 0, 1, 1);
    vec("st_after", 3'd0, 16'd2, 16'd2, 16'd4, 0, 0, 0);
    @(negedge clk);
    vld = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", 16'(sb.size()), 16'd0);
    done = 1'b1;
  end

  initial begin
    fork
      wait (done);
      #100000;
    join_any
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got running want done");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
